// File: rtl/mc_ctrl_pkg.sv
// Multicycle MIPS main control: shared encodings.
// State, opcode, ALUOp and mux-select constants plus the control word.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_REXEC  = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_4     = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // fetch marks the state whose IR/PC writes wait on mem_ready
  typedef struct packed {
    logic       fetch;
    logic       pcwrite;
    logic       pcwritecond;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       memtoreg;
    logic [1:0] pcsource;
    logic [1:0] aluop;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       regwrite;
    logic       regdst;
  } ctrl_t;

endpackage

// File: rtl/mc_main_control_outdec.sv
// Multicycle MIPS main control: state -> control word.
// Pure Moore decode; mem_ready qualification lives in the top.
module mc_ctrl_outdec
  import mc_ctrl_pkg::*;
(
  input  state_t state_i,
  output ctrl_t  ctrl_o
);

  // Moore decode, every field defaults to 0
  always_comb begin
    ctrl_o = '0;
    case (state_i)
      S_FETCH: begin
        ctrl_o.fetch   = 1'b1;
        ctrl_o.memread = 1'b1;
        ctrl_o.alusrcb = SRCB_4;
        ctrl_o.aluop   = ALUOP_ADD;
      end
      S_DECODE: begin
        ctrl_o.alusrcb = SRCB_IMMSH;
        ctrl_o.aluop   = ALUOP_ADD;
      end
      S_MEMADR, S_ADDIEX: begin
        ctrl_o.alusrca = 1'b1;
        ctrl_o.alusrcb = SRCB_IMM;
        ctrl_o.aluop   = ALUOP_ADD;
      end
      S_MEMRD: begin
        ctrl_o.memread = 1'b1;
        ctrl_o.iord    = 1'b1;
      end
      S_MEMWB: begin
        ctrl_o.regwrite = 1'b1;
        ctrl_o.memtoreg = 1'b1;
      end
      S_MEMWR: begin
        ctrl_o.iord     = 1'b1;
        ctrl_o.memwrite = 1'b1;
      end
      S_REXEC: begin
        ctrl_o.alusrca = 1'b1;
        ctrl_o.alusrcb = SRCB_B;
        ctrl_o.aluop   = ALUOP_FUNCT;
      end
      S_RWB: begin
        ctrl_o.regwrite = 1'b1;
        ctrl_o.regdst   = 1'b1;
      end
      S_BRANCH: begin
        ctrl_o.alusrca     = 1'b1;
        ctrl_o.alusrcb     = SRCB_B;
        ctrl_o.aluop       = ALUOP_SUB;
        ctrl_o.pcwritecond = 1'b1;
        ctrl_o.pcsource    = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        ctrl_o.pcwrite  = 1'b1;
        ctrl_o.pcsource = PCSRC_JUMP;
      end
      S_ADDIWB: begin
        ctrl_o.regwrite = 1'b1;
      end
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/mc_main_control.sv
// Multicycle MIPS main control FSM with mem_ready handshake.
// Holds state, fetch counter and sticky illegal-opcode flag.
module mc_main_control
  import mc_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       op,
  input  logic             mem_ready,
  output logic             pcwrite,
  output logic             pcwritecond,
  output logic             iord,
  output logic             memread,
  output logic             memwrite,
  output logic             memtoreg,
  output logic             irwrite,
  output logic [1:0]       pcsource,
  output logic             aluop1,
  output logic             aluop0,
  output logic             alusrca,
  output logic [1:0]       alusrcb,
  output logic             regwrite,
  output logic             regdst,
  output logic [CNT_W-1:0] instr_count,
  output logic             bad_op
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bad_q, bad_d;
  ctrl_t            ctrl;
  logic             fetch_go;

  mc_ctrl_outdec u_outdec (
    .state_i (state_q),
    .ctrl_o  (ctrl)
  );

  // State, counter and sticky flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
      bad_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bad_q   <= bad_d;
    end
  end

  // Next-state, fetch counting and illegal-opcode capture
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bad_d   = bad_q;
    case (state_q)
      S_FETCH: begin
        if (mem_ready) begin
          state_d = S_DECODE;
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      S_DECODE: begin
        unique case (1'b1)
          (op == OP_LW), (op == OP_SW): state_d = S_MEMADR;
          (op == OP_RTYPE): state_d = S_REXEC;
          (op == OP_BEQ):   state_d = S_BRANCH;
          (op == OP_J):     state_d = S_JUMP;
          (op == OP_ADDI):  state_d = S_ADDIEX;
          default: begin
            state_d = S_FETCH;
            bad_d   = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        if (op == OP_SW)      state_d = S_MEMWR;
        else if (op == OP_LW) state_d = S_MEMRD;
        else                  state_d = S_FETCH;
      end
      S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWR:  if (mem_ready) state_d = S_FETCH;
      S_REXEC:  state_d = S_RWB;
      S_ADDIEX: state_d = S_ADDIWB;
      S_MEMWB, S_RWB, S_ADDIWB, S_BRANCH, S_JUMP:
        state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  // Reset blanks every control output in the same cycle
  assign fetch_go    = ctrl.fetch & mem_ready;
  assign pcwrite     = rst_n & (ctrl.pcwrite | fetch_go);
  assign irwrite     = rst_n & fetch_go;
  assign pcwritecond = rst_n & ctrl.pcwritecond;
  assign iord        = rst_n & ctrl.iord;
  assign memread     = rst_n & ctrl.memread;
  assign memwrite    = rst_n & ctrl.memwrite;
  assign memtoreg    = rst_n & ctrl.memtoreg;
  assign pcsource    = ctrl.pcsource & {2{rst_n}};
  assign aluop1      = rst_n & ctrl.aluop[1];
  assign aluop0      = rst_n & ctrl.aluop[0];
  assign alusrca     = rst_n & ctrl.alusrca;
  assign alusrcb     = ctrl.alusrcb & {2{rst_n}};
  assign regwrite    = rst_n & ctrl.regwrite;
  assign regdst      = rst_n & ctrl.regdst;
  assign instr_count = cnt_q;
  assign bad_op      = bad_q;

endmodule

// File: tb/tb_mc_main_control.sv
// Bench for mc_main_control: phase-level reference model,
// randomized opcodes, stalls and mid-operation reset.
module tb_mc_main_control;

  localparam int CW = 8;

  localparam logic [5:0] T_R    = 6'b000000;
  localparam logic [5:0] T_LW   = 6'b100011;
  localparam logic [5:0] T_SW   = 6'b101011;
  localparam logic [5:0] T_BEQ  = 6'b000100;
  localparam logic [5:0] T_J    = 6'b000010;
  localparam logic [5:0] T_ADDI = 6'b001000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [5:0]    op = '0;
  logic          mem_ready = 1'b0;
  logic          pcwrite, pcwritecond, iord, memread, memwrite;
  logic          memtoreg, irwrite, aluop1, aluop0, alusrca;
  logic          regwrite, regdst, bad_op;
  logic [1:0]    pcsource, alusrcb;
  logic [CW-1:0] instr_count;
  logic [15:0]   obs;

  int            checks = 0;
  int            errors = 0;
  logic [CW-1:0] m_cnt = '0;
  bit            m_bad = 1'b0;
  string         phases[$];

  mc_main_control #(.CNT_W(CW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .op          (op),
    .mem_ready   (mem_ready),
    .pcwrite     (pcwrite),
    .pcwritecond (pcwritecond),
    .iord        (iord),
    .memread     (memread),
    .memwrite    (memwrite),
    .memtoreg    (memtoreg),
    .irwrite     (irwrite),
    .pcsource    (pcsource),
    .aluop1      (aluop1),
    .aluop0      (aluop0),
    .alusrca     (alusrca),
    .alusrcb     (alusrcb),
    .regwrite    (regwrite),
    .regdst      (regdst),
    .instr_count (instr_count),
    .bad_op      (bad_op)
  );

  always #5 clk = ~clk;

  assign obs = {pcwrite, pcwritecond, iord, memread, memwrite,
                memtoreg, irwrite, pcsource, aluop1, aluop0,
                alusrca, alusrcb, regwrite, regdst};

  function automatic bit legal(logic [5:0] o);
    return o inside {T_R, T_LW, T_SW, T_BEQ, T_J, T_ADDI};
  endfunction

  // Control word the datapath must see in a named phase
  function automatic logic [15:0] exp_word(string ph, bit rdy);
    logic pcw, pcwc, io, mrd, mwr, m2r, irw, asa, rw, rd;
    logic [1:0] pcs, aop, asb;
    {pcw, pcwc, io, mrd, mwr, m2r, irw, asa, rw, rd} = '0;
    pcs = 2'b00; aop = 2'b00; asb = 2'b00;
    case (ph)
      "fetch":  begin mrd = 1; asb = 2'b01; irw = rdy; pcw = rdy; end
      "decode": asb = 2'b11;
      "memadr": begin asa = 1; asb = 2'b10; end
      "memrd":  begin mrd = 1; io = 1; end
      "memwb":  begin rw = 1; m2r = 1; end
      "memwr":  begin io = 1; mwr = 1; end
      "rexec":  begin asa = 1; aop = 2'b10; end
      "rwb":    begin rw = 1; rd = 1; end
      "branch": begin asa = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; end
      "jump":   begin pcw = 1; pcs = 2'b10; end
      "addiex": begin asa = 1; asb = 2'b10; end
      "addiwb": rw = 1;
      default: ;
    endcase
    return {pcw, pcwc, io, mrd, mwr, m2r, irw, pcs, aop,
            asa, asb, rw, rd};
  endfunction

  // Sequence of phases an instruction walks through
  function automatic void build_route(logic [5:0] o);
    phases = {"fetch", "decode"};
    case (o)
      T_LW:   phases = {phases, "memadr", "memrd", "memwb"};
      T_SW:   phases = {phases, "memadr", "memwr"};
      T_R:    phases = {phases, "rexec", "rwb"};
      T_BEQ:  phases.push_back("branch");
      T_J:    phases.push_back("jump");
      T_ADDI: phases = {phases, "addiex", "addiwb"};
      default: ;
    endcase
  endfunction

  // Execute one instruction; stall counts < 0 mean random stalls
  task automatic run_instr(input logic [5:0] o, input int f_stall,
                           input int m_stall, input int pct,
                           output int cycles, output int rw_pulses);
    bit rdy;
    bit waits;
    int want;
    int k;
    build_route(o);
    cycles = 0;
    rw_pulses = 0;
    foreach (phases[i]) begin
      waits = (phases[i] == "fetch") || (phases[i] == "memrd") ||
              (phases[i] == "memwr");
      want = (phases[i] == "fetch") ? f_stall : m_stall;
      k = 0;
      do begin
        if (!waits)        rdy = 1'($urandom_range(1, 0));
        else if (want >= 0) rdy = (k >= want);
        else rdy = (k >= 20) || ($urandom_range(99) >= pct);
        @(negedge clk);
        op = (phases[i] == "fetch") ? 6'($urandom) : o;
        mem_ready = rdy;
        #1;
        checks++;
        if (obs !== exp_word(phases[i], rdy)) begin
          errors++;
          $display("FAIL ctrl op=%b ph=%s got=%h exp=%h",
                   o, phases[i], obs, exp_word(phases[i], rdy));
        end
        checks++;
        if (instr_count !== m_cnt) begin
          errors++;
          $display("FAIL instr_count ph=%s got=%0d exp=%0d",
                   phases[i], instr_count, m_cnt);
        end
        checks++;
        if (bad_op !== m_bad) begin
          errors++;
          $display("FAIL bad_op ph=%s got=%b exp=%b",
                   phases[i], bad_op, m_bad);
        end
        checks++;
        if ((memread && memwrite) || (aluop1 && aluop0)) begin
          errors++;
          $display("FAIL invariant ph=%s rd=%b wr=%b aluop=%b%b",
                   phases[i], memread, memwrite, aluop1, aluop0);
        end
        if (regwrite) rw_pulses++;
        cycles++;
        k++;
        @(posedge clk);
        if (phases[i] == "fetch" && rdy) m_cnt++;
        if (phases[i] == "decode" && !legal(o)) m_bad = 1'b1;
      end while (waits && !rdy);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    mem_ready = 1'b0;
    m_cnt = '0;
    m_bad = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      op = 6'($urandom);
      mem_ready = 1'($urandom);
      #1;
      checks++;
      if (obs !== 16'h0 || instr_count !== '0 || bad_op !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold got=%h cnt=%0d bad=%b exp=0",
                 obs, instr_count, bad_op);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    mem_ready = 1'b0;
    m_cnt = '0;
    m_bad = 1'b0;
    #1;
    checks++;
    if (obs !== exp_word("fetch", 1'b0)) begin
      errors++;
      $display("FAIL reset_release got=%h exp=%h",
               obs, exp_word("fetch", 1'b0));
    end
  endtask

  task automatic test_rtype();
    int cyc, rw;
    run_instr(T_R, 0, 0, 0, cyc, rw);
    checks++;
    if (cyc != 4 || rw != 1) begin
      errors++;
      $display("FAIL rtype_latency got=%0d/%0d exp=4/1", cyc, rw);
    end
    #1;
    checks++;
    if (instr_count !== CW'(1)) begin
      errors++;
      $display("FAIL rtype_count got=%0d exp=1", instr_count);
    end
  endtask

  task automatic test_lw();
    int cyc, rw;
    run_instr(T_LW, 0, 2, 0, cyc, rw);
    checks++;
    if (cyc != 7 || rw != 1) begin
      errors++;
      $display("FAIL lw_latency got=%0d/%0d exp=7/1", cyc, rw);
    end
  endtask

  task automatic test_beq();
    int cyc, rw;
    run_instr(T_BEQ, 0, 0, 0, cyc, rw);
    checks++;
    if (cyc != 3 || rw != 0) begin
      errors++;
      $display("FAIL beq_latency got=%0d/%0d exp=3/0", cyc, rw);
    end
  endtask

  task automatic test_illegal();
    int cyc, rw;
    run_instr(6'b111111, 0, 0, 0, cyc, rw);
    #1;
    checks++;
    if (cyc != 2 || bad_op !== 1'b1) begin
      errors++;
      $display("FAIL illegal got=%0d/%b exp=2/1", cyc, bad_op);
    end
    run_instr(T_J, 0, 0, 0, cyc, rw);
    #1;
    checks++;
    if (cyc != 3 || bad_op !== 1'b1) begin
      errors++;
      $display("FAIL jump_after_bad got=%0d/%b exp=3/1", cyc, bad_op);
    end
  endtask

  task automatic test_random();
    int cyc, rw, nom, stalls_ok;
    logic [5:0] o;
    logic [5:0] tbl [6] = '{T_R, T_LW, T_SW, T_BEQ, T_J, T_ADDI};
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(7) == 0) o = 6'($urandom);
      else o = tbl[$urandom_range(5)];
      run_instr(o, -1, -1, 30, cyc, rw);
      nom = legal(o) ? phases.size() : 2;
      stalls_ok = (cyc >= nom) ? 1 : 0;
      checks++;
      if (stalls_ok == 0 ||
          rw != ((o == T_R || o == T_LW || o == T_ADDI) ? 1 : 0)) begin
        errors++;
        $display("FAIL random op=%b cyc=%0d nom=%0d rw=%0d",
                 o, cyc, nom, rw);
      end
    end
  endtask

  task automatic test_wrap();
    int cyc, rw;
    do_reset();
    for (int n = 0; n < (1 << CW) + 2; n++)
      run_instr(T_J, 0, 0, 0, cyc, rw);
    #1;
    checks++;
    if (instr_count !== CW'(2)) begin
      errors++;
      $display("FAIL count_wrap got=%0d exp=2", instr_count);
    end
  endtask

  task automatic test_midop_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      op = T_SW;
      mem_ready = 1'b1;
    end
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    checks++;
    if (memwrite !== 1'b1) begin
      errors++;
      $display("FAIL memwr_wait got=%b exp=1", memwrite);
    end
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (memwrite !== 1'b0 || obs !== 16'h0 || instr_count !== '0) begin
      errors++;
      $display("FAIL midop_reset wr=%b got=%h cnt=%0d exp=0/0/0",
               memwrite, obs, instr_count);
    end
    m_cnt = '0;
    m_bad = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    mem_ready = 1'b0;
    #1;
    checks++;
    if (obs !== exp_word("fetch", 1'b0)) begin
      errors++;
      $display("FAIL midop_release got=%h exp=%h",
               obs, exp_word("fetch", 1'b0));
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw();
    test_beq();
    test_illegal();
    test_random();
    test_wrap();
    test_midop_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
